id_ex_operand_stage: RTL

- ID/EX pipeline register and operand-forwarding stage of the 5-stage 16-bit pipeline.
- Latches the decoded operands and control fields from ID each cycle.
- Drives the resolved 16-bit operand pair (ex_inA/ex_inB) into the EX-stage ALU, whose logic units, including the 16-bit XOR, consume them directly.
- Handles stall (hold), flush (bubble), EX/MEM and MEM/WB forwarding, and write-back capture while held.

---
 rtl/id_ex_operand_stage.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding for the 16-bit 5-stage pipeline.
// Each operand slot (A = Rs, B = Rt) is one lane instance: held data, specifier, and its bypass mux.

module id_ex_operand_lane #(
  parameter int WIDTH = 16,
  parameter int RBITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic [WIDTH-1:0] idData,
  input  logic [RBITS-1:0] idSpec,
  input  logic             exmemRegwrite,
  input  logic [RBITS-1:0] exmemRd,
  input  logic [WIDTH-1:0] exmemResult,
  input  logic             memwbRegwrite,
  input  logic [RBITS-1:0] memwbRd,
  input  logic [WIDTH-1:0] memwbResult,
  input  logic             bypass,
  input  logic [WIDTH-1:0] bypassData,
  output logic [WIDTH-1:0] fwdData
);

  logic [WIDTH-1:0] heldData;
  logic [RBITS-1:0] heldSpec;
  logic             exmemHit;
  logic             memwbHit;

  assign exmemHit = exmemRegwrite && (exmemRd == heldSpec);
  assign memwbHit = memwbRegwrite && (memwbRd == heldSpec);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      heldData <= '0;
      heldSpec <= '0;
    end else if (stall) begin
      // Producer may retire while we wait; capture its value so release sees it.
      if (memwbHit) heldData <= memwbResult;
    end else begin
      heldData <= idData;
      heldSpec <= idSpec;
    end
  end

  // Youngest producer wins; an immediate operand bypasses forwarding entirely.
  always_comb begin
    fwdData = heldData;
    if (bypass)        fwdData = bypassData;
    else if (exmemHit) fwdData = exmemResult;
    else if (memwbHit) fwdData = memwbResult;
  end

endmodule

module id_ex_operand_stage #(
  parameter int WIDTH = 16,
  parameter int RBITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rdata1,
  input  logic [WIDTH-1:0] id_rdata2,
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  input  logic [RBITS-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_use_imm,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [2:0]       id_alu_op,
  input  logic             exmem_regwrite,
  input  logic [RBITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_regwrite,
  input  logic [RBITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_inA,
  output logic [WIDTH-1:0] ex_inB,
  output logic [2:0]       ex_alu_op,
  output logic [RBITS-1:0] ex_rd,
  output logic             ex_regwrite
);

  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic             valid;
    logic [RBITS-1:0] rd;
    logic             regwrite;
    logic             useImm;
    logic [WIDTH-1:0] imm;
    logic [2:0]       aluOp;
  } ctrl_t;

  ctrl_t ctrlQ;
  ctrl_t ctrlD;

  logic [NUM_LANES-1:0][WIDTH-1:0] laneIdData;
  logic [NUM_LANES-1:0][RBITS-1:0] laneIdSpec;
  logic [NUM_LANES-1:0]            laneBypass;
  logic [NUM_LANES-1:0][WIDTH-1:0] laneFwd;

  assign laneIdData = {id_rdata2, id_rdata1};
  assign laneIdSpec = {id_rt, id_rs};
  assign laneBypass = {ctrlQ.useImm, 1'b0};

  assign ctrlD = '{valid:    id_valid,
                   rd:       id_rd,
                   regwrite: id_regwrite,
                   useImm:   id_use_imm,
                   imm:      id_imm,
                   aluOp:    id_alu_op};

  always_ff @(posedge clk) begin
    if (rst || flush) ctrlQ <= '0;
    else if (!stall)  ctrlQ <= ctrlD;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
    id_ex_operand_lane #(.WIDTH(WIDTH), .RBITS(RBITS)) uLane (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .stall         (stall),
      .idData        (laneIdData[l]),
      .idSpec        (laneIdSpec[l]),
      .exmemRegwrite (exmem_regwrite),
      .exmemRd       (exmem_rd),
      .exmemResult   (exmem_result),
      .memwbRegwrite (memwb_regwrite),
      .memwbRd       (memwb_rd),
      .memwbResult   (memwb_result),
      .bypass        (laneBypass[l]),
      .bypassData    (ctrlQ.imm),
      .fwdData       (laneFwd[l])
    );
  end

  assign ex_valid    = ctrlQ.valid;
  assign ex_inA      = laneFwd[0];
  assign ex_inB      = laneFwd[1];
  assign ex_alu_op   = ctrlQ.aluOp;
  assign ex_rd       = ctrlQ.rd;
  assign ex_regwrite = ctrlQ.regwrite & ctrlQ.valid;

endmodule
